aes_shift_rows_stage: RTL and testbench
=======================================

# aes_shift_rows_stage

Parametrised, pipelined AES/Rijndael ShiftRows unit for the cipher datapath, sitting between SubBytes and MixColumns in the round pipeline. It supports forward, inverse and bypass modes per transaction, Rijndael block widths of 128/192/256 bits, and a valid/ready handshake. A 2-entry output buffer gives full throughput, with `in_ready` that does not depend combinationally on `out_ready`.

## Interface
- `NB`, 4 — state columns; legal values 4, 6, 8; data width `W = 32*NB`
- `TAG_W`, 4 — width of the sideband tag carried with each block

- `clk` input 1 — clock, all state on rising edge
- `n_rst` input 1 — reset, asynchronous, active-low
- `clear` input 1 — synchronous flush of buffer and error flag
- `in_valid` input 1 — input block present
- `in_ready` output 1 — stage can accept
- `in_data` input W — state, column-major, byte (r,c) at index 4c+r, byte 0 in MSBs
- `in_mode` input 2 — 00 forward, 01 inverse, 10 bypass, 11 reserved
- `in_tag` input TAG_W — sideband, returned unchanged
- `out_valid` output 1 — output block present
- `out_ready` input 1 — downstream accepts
- `out_data` output W — permuted state, same byte layout
- `out_tag` output TAG_W — tag of the head entry
- `err` output 1 — sticky; set when a reserved mode is accepted

## Operation
- Row offsets: for NB 4 and 6, rows 0..3 use offsets 0,1,2,3. For NB 8, rows 0..3 use offsets 0,1,3,4.
- Forward mode: out(r,c) = in(r, (c+off_r) mod NB).
- Inverse mode: out(r,c) = in(r, (c−off_r) mod NB).
- Bypass mode: out = in.
- Reserved mode (11): the block is passed as bypass and `err` is set on acceptance.
- The permutation is applied at input. The buffer stores the permuted data plus the tag.
- Buffer: 2-entry FIFO with count 0..2.
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
- `in_ready = (count != 2) && !clear`.
- `out_valid = (count != 0)`.
- `out_data` and `out_tag` come from the head entry. Both are all-zero when `out_valid` is 0.
- Push and pop in the same cycle: count is unchanged and order is preserved (FIFO).
- `clear`:
  - Count goes to 0 and stored entries are dropped.
  - `err` goes to 0.
  - Any same-cycle push is ignored, because `in_ready` is 0 that cycle.
- Order is strictly FIFO. No reordering and no drops except via `clear`.

## Timing
- Reset (`n_rst` low, asynchronous):
  - count=0, `err`=0
  - `out_valid`=0, `out_data`=0, `out_tag`=0
  - `in_ready`=1 (unless `clear` is high)
- Latency: a block accepted at edge k is presented with `out_valid`=1 from edge k onward, i.e. in the cycle after acceptance.
- Throughput: one block per cycle while `out_ready` stays high.
- Backpressure:
  - With `out_ready` low, two blocks are accepted, then `in_ready` drops in the following cycle.
  - `in_ready` rises the cycle after the first pop.
- Holding rule: `out_data` and `out_tag` stay stable while `out_valid && !out_ready`.
- `clear` takes effect at the edge where it is sampled high. `out_valid`=0 from the next cycle.
- Reset mid-transfer: all buffered blocks are lost, and no output handshake completes during reset.

## Structure
- Package `aes_pkg`:
  - `sr_mode_t` enum (`SR_FWD`, `SR_INV`, `SR_BYP`, `SR_RSV`)
  - function `sr_offset(nb, row)`
  - `localparam` legal-NB check, elaborated with `$error` on an illegal value
- Sub-module `aes_sr_perm`: purely combinational, parametrised by `NB`, mode in, W-bit data in/out. Instantiated once at the input.
- The top level holds the 2-entry FIFO (two data+tag registers, read/write pointers, count), `err`, and the handshake logic.

## Test plan
- NB=4, forward, input d42711aee0bf98f1b8b45de51e415230 → out d4bf5d30e0b452aeb84111f11e2798e5 in the cycle after acceptance, tag echoed.
- NB=4, inverse, input d4bf5d30e0b452aeb84111f11e2798e5 → out d42711aee0bf98f1b8b45de51e415230.
  - Also: mode 10 returns the input unchanged.
  - Also: mode 11 returns the input unchanged and sets `err`, which stays 1 until `clear`.
- NB=8, forward, input bytes 00..1f ascending → output column 0 = 00 05 0e 13.
  - Forward then inverse of any random input returns the original.
- Backpressure, tags 1,2,3 with `out_ready`=0:
  - Tags 1 and 2 are accepted; `in_ready`=0 the cycle after the second acceptance.
  - Raise `out_ready` → outputs in order 1,2,3 with no loss or duplication.
  - Stable `out_data` while stalled.
- `clear` with 2 entries buffered and `in_valid`=1 in the same cycle:
  - Next cycle `out_valid`=0, `err`=0, and the input is not accepted.
  - The following push proceeds normally.
- Assert `n_rst` asynchronously mid-stream → all outputs zero immediately and `in_ready`=1.
  - Streaming 100 random back-to-back blocks after reset release gives 100 correct outputs at 1 per cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES ShiftRows datapath stage.
package aes_pkg;

    // Per-transaction permutation mode; SR_RSV behaves as bypass and flags an error.
    typedef enum logic [1:0] {
        SR_FWD = 2'b00,
        SR_INV = 2'b01,
        SR_BYP = 2'b10,
        SR_RSV = 2'b11
    } sr_mode_t;

    // Rijndael row rotation amount; 256-bit blocks use 0,1,3,4 instead of 0,1,2,3.
    function automatic int unsigned sr_offset(int unsigned nb, int unsigned row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

    // Only the Rijndael block widths 128/192/256 are supported.
    function automatic bit sr_nb_legal(int unsigned nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

// File: rtl/aes_shift_rows_stage_if.sv
// Handshake bundle for the ShiftRows stage: input stream, output stream, flush and error flag.
interface aes_shift_rows_stage_if #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned W = 32 * NB;

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             err;

    // Upstream/downstream environment view.
    modport master (
        output clear, in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, err
    );

    // Stage view.
    modport slave (
        input  clear, in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, err
    );
endinterface

// File: rtl/aes_sr_perm.sv
// Combinational ShiftRows byte permutation (forward / inverse / pass-through).
// Byte (r,c) sits at index 4c+r, byte 0 occupying the MSBs.
module aes_sr_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  sr_mode_t          mode_i,
    input  logic [32*NB-1:0]  data_i,
    output logic [32*NB-1:0]  data_o
);
    localparam int unsigned W = 32 * NB;

    logic [W-1:0] fwd_data;
    logic [W-1:0] inv_data;

    // Pure wiring: each output byte picks a fixed source byte from the same row.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned Off    = sr_offset(NB, r);
            localparam int unsigned FwdSrc = (c + Off) % NB;
            localparam int unsigned InvSrc = (c + NB - Off) % NB;
            localparam int unsigned DstHi  = W - 1 - 8 * (4 * c + r);
            localparam int unsigned FwdHi  = W - 1 - 8 * (4 * FwdSrc + r);
            localparam int unsigned InvHi  = W - 1 - 8 * (4 * InvSrc + r);

            assign fwd_data[DstHi -: 8] = data_i[FwdHi -: 8];
            assign inv_data[DstHi -: 8] = data_i[InvHi -: 8];
        end
    end

    // Select the permutation; reserved mode passes data through like bypass.
    always_comb begin
        data_o = data_i;
        case (mode_i)
            SR_FWD:  data_o = fwd_data;
            SR_INV:  data_o = inv_data;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/aes_shift_rows_stage.sv
// Pipelined ShiftRows stage: permutes on entry, then a 2-entry FIFO decouples the handshakes
// so in_ready never depends on out_ready.
module aes_shift_rows_stage
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic                   clk,
    input logic                   n_rst,
    aes_shift_rows_stage_if.slave bus
);
    localparam int unsigned W    = 32 * NB;
    localparam bit          NbOk = sr_nb_legal(NB);

    if (!NbOk) begin : g_bad_nb
        $error("aes_shift_rows_stage: NB must be 4, 6 or 8");
    end

    logic [W-1:0]     perm_data;
    logic [W-1:0]     data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             err_q, err_d;
    logic             push, pop;
    sr_mode_t         in_mode;

    assign in_mode = sr_mode_t'(bus.in_mode);

    aes_sr_perm #(
        .NB (NB)
    ) u_perm (
        .mode_i (in_mode),
        .data_i (bus.in_data),
        .data_o (perm_data)
    );

    assign bus.in_ready  = (count_q != 2'd2) && !bus.clear;
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Head entry is gated so an empty buffer always presents zeros.
    assign bus.out_data = bus.out_valid ? data_q[rd_ptr_q] : '0;
    assign bus.out_tag  = bus.out_valid ? tag_q[rd_ptr_q]  : '0;
    assign bus.err      = err_q;

    // Next-state for pointers, occupancy and the sticky error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (bus.clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            err_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (push && in_mode == SR_RSV) begin
                err_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Buffer storage: write the permuted block and its tag at the write pointer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= perm_data;
            tag_q[wr_ptr_q]  <= bus.in_tag;
        end
    end

endmodule

// File: tb/tb_aes_shift_rows_stage.sv
// Self-checking bench for aes_shift_rows_stage (NB=4 and NB=8 instances).
module tb_aes_shift_rows_stage;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    aes_shift_rows_stage_if #(.NB(4), .TAG_W(4)) bus4 ();
    aes_shift_rows_stage_if #(.NB(8), .TAG_W(4)) bus8 ();

    aes_shift_rows_stage #(.NB(4), .TAG_W(4)) dut4 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus4.slave)
    );

    aes_shift_rows_stage #(.NB(8), .TAG_W(4)) dut8 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus8.slave)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: rotate each row as a list of bytes.
    function automatic logic [255:0] sr_model(logic [255:0] d, int nb, logic [1:0] mode);
        logic [255:0] res;
        logic [7:0]   row[$];
        int           off;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            row.delete();
            for (int c = 0; c < nb; c++) row.push_back(d[32*nb-1-8*(4*c+r) -: 8]);
            off = (nb == 8 && r >= 2) ? r + 1 : r;
            if (mode == 2'b00) begin
                repeat (off) row.push_back(row.pop_front());
            end else if (mode == 2'b01) begin
                repeat (off) row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++) res[32*nb-1-8*(4*c+r) -: 8] = row[c];
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Single transfer on the NB=4 instance; entered just after a rising edge, buffer empty.
    task automatic send4(input logic [127:0] d, input logic [1:0] m, input logic [3:0] t,
                         input logic [127:0] exp, input string name);
        bus4.in_data  = d;
        bus4.in_mode  = m;
        bus4.in_tag   = t;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        check_eq({name, "_in_ready"}, bus4.in_ready, 1'b1);
        check_eq({name, "_pre_valid"}, bus4.out_valid, 1'b0);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        @(negedge clk);
        check_eq({name, "_valid"}, bus4.out_valid, 1'b1);
        check_eq({name, "_data"}, bus4.out_data, exp);
        check_eq({name, "_tag"}, bus4.out_tag, t);
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [255:0] d, input logic [1:0] m, input logic [3:0] t,
                         output logic [255:0] o);
        bus8.in_data  = d;
        bus8.in_mode  = m;
        bus8.in_tag   = t;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        check_eq("nb8_in_ready", bus8.in_ready, 1'b1);
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        check_eq("nb8_valid", bus8.out_valid, 1'b1);
        check_eq("nb8_tag", bus8.out_tag, t);
        o = bus8.out_data;
        @(posedge clk);
        #1;
    endtask

    // Stream n random blocks through the NB=4 instance against a scoreboard queue.
    task automatic stream(input int n, input bit rdy_rand);
        logic [127:0] exp_d[$];
        logic [3:0]   exp_t[$];
        int sent = 0, got = 0, cyc = 0;
        bit acc;
        bus4.in_valid = 1'b0;
        while (got < n && cyc < 20 * n + 20) begin
            if (!bus4.in_valid && sent < n) begin
                bus4.in_data  = rand128();
                bus4.in_mode  = 2'($urandom_range(0, 2));
                bus4.in_tag   = 4'($urandom);
                bus4.in_valid = 1'b1;
            end
            bus4.out_ready = rdy_rand ? 1'($urandom) : 1'b1;
            @(negedge clk);
            acc = bus4.in_valid && bus4.in_ready;
            if (bus4.out_valid && bus4.out_ready) begin
                if (exp_d.size() == 0) begin
                    check_eq("stream_unexpected", 1'b1, 1'b0);
                end else begin
                    check_eq("stream_data", bus4.out_data, exp_d.pop_front());
                    check_eq("stream_tag", bus4.out_tag, exp_t.pop_front());
                end
                got++;
            end
            if (acc) begin
                exp_d.push_back(sr_model(bus4.in_data, 4, bus4.in_mode)); 
                exp_t.push_back(bus4.in_tag);
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) bus4.in_valid = 1'b0;
            cyc++;
        end
        check_eq("stream_count", got, n);
        if (!rdy_rand) check_eq("stream_cycles", cyc, n + 1);
        bus4.out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] d, held;
        logic [127:0] bp_d[3];
        logic [255:0] d8, o8, o8b;
        int           got, acc_cyc;
        bit           acc;

        bus4.clear = 0; bus4.in_valid = 0; bus4.in_data = '0; bus4.in_mode = 0;
        bus4.in_tag = 0; bus4.out_ready = 1;
        bus8.clear = 0; bus8.in_valid = 0; bus8.in_data = '0; bus8.in_mode = 0;
        bus8.in_tag = 0; bus8.out_ready = 1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", bus4.out_valid, 1'b0);
        check_eq("rst_out_data", bus4.out_data, '0);
        check_eq("rst_out_tag", bus4.out_tag, '0);
        check_eq("rst_in_ready", bus4.in_ready, 1'b1);
        check_eq("rst_err", bus4.err, 1'b0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer vectors and modes
        send4(128'hd42711aee0bf98f1b8b45de51e415230, 2'b00, 4'h5,
              128'hd4bf5d30e0b452aeb84111f11e2798e5, "kat_fwd");
        send4(128'hd4bf5d30e0b452aeb84111f11e2798e5, 2'b01, 4'ha,
              128'hd42711aee0bf98f1b8b45de51e415230, "kat_inv");
        d = rand128();
        send4(d, 2'b10, 4'h3, d, "bypass");
        @(negedge clk);
        check_eq("err_after_bypass", bus4.err, 1'b0);
        @(posedge clk);
        #1;
        d = rand128();
        send4(d, 2'b11, 4'hc, d, "reserved");
        @(negedge clk);
        check_eq("err_set", bus4.err, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            d = rand128();
            send4(d, 2'(i % 2), 4'(i), 128'(sr_model(d, 4, 2'(i % 2))), "rand_mode");
        end

        // NB=8 known answer and forward/inverse round trip
        for (int i = 0; i < 32; i++) d8[255-8*i -: 8] = 8'(i);
        send8(d8, 2'b00, 4'h7, o8);
        check_eq("nb8_col0", o8[255:224], 32'h00050e13);
        check_eq("nb8_fwd_model", o8, sr_model(d8, 8, 2'b00));
        for (int i = 0; i < 3; i++) begin
            d8 = {rand128(), rand128()};
            send8(d8, 2'b00, 4'(i), o8);
            check_eq("nb8_rand_fwd", o8, sr_model(d8, 8, 2'b00));
            send8(o8, 2'b01, 4'(i), o8b);
            check_eq("nb8_roundtrip", o8b, d8);
        end

        // Backpressure: tags 1,2,3 with out_ready low
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) bp_d[i] = rand128();
        for (int i = 0; i < 2; i++) begin
            bus4.in_data = bp_d[i]; bus4.in_mode = 2'b00; bus4.in_tag = 4'(i + 1);
            bus4.in_valid = 1'b1;
            @(negedge clk);
            check_eq("bp_accept", bus4.in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        bus4.in_data = bp_d[2]; bus4.in_tag = 4'd3;
        @(negedge clk);
        check_eq("bp_full", bus4.in_ready, 1'b0);
        check_eq("bp_head_tag", bus4.out_tag, 4'd1);
        held = bus4.out_data;
        check_eq("bp_head_data", held, 128'(sr_model(bp_d[0], 4, 2'b00)));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("bp_hold_data", bus4.out_data, held);
        check_eq("bp_hold_tag", bus4.out_tag, 4'd1);
        check_eq("bp_still_full", bus4.in_ready, 1'b0);
        @(posedge clk);
        #1 bus4.out_ready = 1'b1;
        got = 0;
        acc_cyc = -1;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            @(negedge clk);
            acc = bus4.in_valid && bus4.in_ready;
            if (acc) acc_cyc = cyc;
            if (bus4.out_valid) begin
                check_eq("bp_order_tag", bus4.out_tag, 4'(got + 1));
                check_eq("bp_order_data", bus4.out_data, 128'(sr_model(bp_d[got], 4, 2'b00)));
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) bus4.in_valid = 1'b0;
        end
        check_eq("bp_count", got, 3);
        check_eq("bp_ready_rise", acc_cyc, 1);
        @(negedge clk);
        check_eq("bp_drained", bus4.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Clear with two entries buffered and a competing push
        check_eq("err_sticky", bus4.err, 1'b1);
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus4.in_data = rand128(); bus4.in_mode = 2'b10; bus4.in_tag = 4'(8 + i);
            bus4.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus4.in_data = rand128();
        bus4.clear = 1'b1;
        @(negedge clk);
        check_eq("clr_in_ready", bus4.in_ready, 1'b0);
        check_eq("clr_pre_valid", bus4.out_valid, 1'b1);
        @(posedge clk);
        #1 bus4.clear = 1'b0;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        check_eq("clr_out_valid", bus4.out_valid, 1'b0);
        check_eq("clr_err", bus4.err, 1'b0);
        check_eq("clr_out_data", bus4.out_data, '0);
        check_eq("clr_in_ready_after", bus4.in_ready, 1'b1);
        @(posedge clk);
        #1 bus4.out_ready = 1'b1;
        d = rand128();
        send4(d, 2'b00, 4'hf, 128'(sr_model(d, 4, 2'b00)), "post_clear");
        @(negedge clk);
        check_eq("post_clear_empty", bus4.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus4.in_data = rand128(); bus4.in_mode = 2'b11; bus4.in_tag = 4'(4 + i);
            bus4.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check_eq("arst_out_valid", bus4.out_valid, 1'b0);
        check_eq("arst_out_data", bus4.out_data, '0);
        check_eq("arst_out_tag", bus4.out_tag, '0);
        check_eq("arst_in_ready", bus4.in_ready, 1'b1);
        check_eq("arst_err", bus4.err, 1'b0);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_held_valid", bus4.out_valid, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        stream(100, 1'b0);
        stream(60, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
